// File: rtl/pcx2mb_req_buf.sv
// pcx2mb_req_buf: buffers PCX requests for one destination before they go
// to the MicroBlaze link FIFO. It captures the first packet in PA and the
// atomic second packet in PX, forwards packets in order, and returns one
// grant pulse for each packet it forwards.
module pcx2mb_req_buf #(
  parameter int PKT_W = 124,
  parameter int DEPTH = 3
) (
  input  logic             rclk,
  input  logic             reset,
  input  logic             pcx_req_pq,
  input  logic             pcx_atom_pq,
  input  logic [PKT_W-1:0] pcx_data_pa,
  input  logic             request_mask_pa,
  input  logic             mb_fifo_full,
  output logic             mb_fifo_wr,
  output logic [PKT_W-1:0] mb_fifo_data,
  output logic             pcx_req_pa,
  output logic             pcx_req_px,
  output logic             pcx_atom_px,
  output logic             pcx_grant_px,
  output logic             ovfl_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Request pipeline and control state
  logic             r_req_pa;
  logic             r_atom_pa;
  logic             r_req_px;
  logic             r_atom_px;
  logic             r_grant_px;
  logic             r_ovfl_err;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  // Entry storage: packet payload plus a tag marking the first half of an atomic pair
  logic [PKT_W-1:0] r_data_mem [DEPTH];
  logic [DEPTH-1:0] r_atom_vec;

  logic w_wr_first;
  logic w_wr_second;
  logic w_wr;
  logic w_wr_atom;
  logic w_not_full;
  logic w_head_atom;
  logic w_pop;
  logic w_accept;
  logic w_ovfl_set;

  // Advance a buffer pointer, wrapping at DEPTH (DEPTH need not be a power of two)
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // The atomic second packet always wins; a masked PA request is dropped without a trace.
  assign w_wr_first  = r_req_pa && !request_mask_pa;
  assign w_wr_second = r_req_px && r_atom_px;
  assign w_wr        = w_wr_first || w_wr_second;
  assign w_wr_atom   = w_wr_second ? 1'b0 : r_atom_pa;

  // An atomic head waits for its partner so that both halves leave on consecutive cycles.
  assign w_not_full  = (r_count != CNT_W'(DEPTH));
  assign w_head_atom = r_atom_vec[r_rd_ptr];
  assign w_pop       = (r_count != '0) && !mb_fifo_full &&
                       (!w_head_atom || (r_count >= CNT_W'(2)));

  // When the buffer is full, a pop in the same cycle frees the slot the write needs.
  assign w_accept    = w_wr && (w_not_full || w_pop);
  assign w_ovfl_set  = (w_wr_first && w_wr_second) || (w_wr && !w_not_full && !w_pop);

  assign mb_fifo_wr   = w_pop;
  assign mb_fifo_data = r_data_mem[r_rd_ptr];
  assign pcx_req_pa   = r_req_pa;
  assign pcx_req_px   = r_req_px;
  assign pcx_atom_px  = r_atom_px;
  assign pcx_grant_px = r_grant_px;
  assign ovfl_err     = r_ovfl_err;

  // Request pipeline: PQ -> PA -> PX, with the atom flag carried alongside
  always_ff @(posedge rclk) begin
    if (reset) begin
      r_req_pa  <= 1'b0;
      r_atom_pa <= 1'b0;
      r_req_px  <= 1'b0;
      r_atom_px <= 1'b0;
    end else begin
      r_req_pa  <= pcx_req_pq;
      r_atom_pa <= pcx_atom_pq;
      r_req_px  <= r_req_pa;
      r_atom_px <= r_atom_pa;
    end
  end

  // Pointers, occupancy, grant and sticky overflow flag
  always_ff @(posedge rclk) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_grant_px <= 1'b0;
      r_ovfl_err <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (w_accept) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_grant_px <= w_pop;
      if (w_ovfl_set) begin
        r_ovfl_err <= 1'b1;
      end
    end
  end

  // Entry write; contents need no reset because occupancy governs what is valid
  always_ff @(posedge rclk) begin
    if (w_accept) begin
      r_data_mem[r_wr_ptr] <= pcx_data_pa;
      r_atom_vec[r_wr_ptr] <= w_wr_atom;
    end
  end

endmodule

// File: tb/tb_pcx2mb_req_buf.sv
// Testbench for pcx2mb_req_buf: cycle tables for single, atomic and masked
// requests, then hand sequences for backpressure/wrap, overflow and reset.
module tb_pcx2mb_req_buf;

  localparam int PKT_W = 124;

  logic             clk = 1'b0;
  logic             reset;
  logic             pcx_req_pq;
  logic             pcx_atom_pq;
  logic [PKT_W-1:0] pcx_data_pa;
  logic             request_mask_pa;
  logic             mb_fifo_full;
  logic             mb_fifo_wr;
  logic [PKT_W-1:0] mb_fifo_data;
  logic             pcx_req_pa;
  logic             pcx_req_px;
  logic             pcx_atom_px;
  logic             pcx_grant_px;
  logic             ovfl_err;

  int total = 0;
  int bad   = 0;
  logic [PKT_W-1:0] sb_q[$];
  logic mon_en = 1'b0;
  logic prev_wr = 1'b0;

  always #5 clk = ~clk;

  pcx2mb_req_buf #(.PKT_W(PKT_W), .DEPTH(3)) dut (
    .rclk            (clk),
    .reset           (reset),
    .pcx_req_pq      (pcx_req_pq),
    .pcx_atom_pq     (pcx_atom_pq),
    .pcx_data_pa     (pcx_data_pa),
    .request_mask_pa (request_mask_pa),
    .mb_fifo_full    (mb_fifo_full),
    .mb_fifo_wr      (mb_fifo_wr),
    .mb_fifo_data    (mb_fifo_data),
    .pcx_req_pa      (pcx_req_pa),
    .pcx_req_px      (pcx_req_px),
    .pcx_atom_px     (pcx_atom_px),
    .pcx_grant_px    (pcx_grant_px),
    .ovfl_err        (ovfl_err)
  );

  typedef struct {
    logic             req;
    logic             atom;
    logic             mask;
    logic [PKT_W-1:0] data;
    logic             push;
    logic             exp_wr;
    logic             exp_grant;
    logic             exp_req_pa;
    logic             exp_req_px;
    logic             exp_atom_px;
    logic             exp_ovfl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic req, logic atom, logic mask, logic [PKT_W-1:0] data,
                              logic push, logic wr, logic g, logic pa, logic px,
                              logic apx, logic ov);
    vec_t v;
    v.req = req; v.atom = atom; v.mask = mask; v.data = data; v.push = push;
    v.exp_wr = wr; v.exp_grant = g; v.exp_req_pa = pa; v.exp_req_px = px;
    v.exp_atom_px = apx; v.exp_ovfl = ov;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, return at the falling edge
  task automatic cyc(input logic req, input logic atom, input logic mask,
                     input logic full, input logic [PKT_W-1:0] data);
    @(posedge clk);
    #1;
    pcx_req_pq      = req;
    pcx_atom_pq     = atom;
    request_mask_pa = mask;
    mb_fifo_full    = full;
    pcx_data_pa     = data;
    @(negedge clk);
  endtask

  // Scoreboard: each forwarded packet must be the oldest expected one; grant follows a write by one cycle
  always @(negedge clk) begin
    if (mon_en) begin
      chk("grant_follows_wr", {127'b0, pcx_grant_px}, {127'b0, prev_wr});
      if (!reset && mb_fifo_wr) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got write data %0h expected no write (t=%0t)",
                   mb_fifo_data, $time);
        end else begin
          chk("sb_data", {4'b0, mb_fifo_data}, {4'b0, sb_q.pop_front()});
        end
      end
      prev_wr = reset ? 1'b0 : mb_fifo_wr;
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [PKT_W-1:0] p;

    // Cycle tables: inputs for the cycle, outputs expected at its falling edge
    // single request A5
    vecs.push_back(mk(1, 0, 0, 124'h0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 124'hA5, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 124'h0,  0, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 124'h0,  0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 124'h0,  0, 0, 0, 0, 0, 0, 0));
    // atomic pair D1/D2: no pop while only D1 is held
    vecs.push_back(mk(1, 1, 0, 124'h0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 124'hD1, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 124'hD2, 1, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 124'h0,  0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 124'h0,  0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 124'h0,  0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 124'h0,  0, 0, 0, 0, 0, 0, 0));
    // speculative request masked in PA: no entry, no grant, px still propagates
    vecs.push_back(mk(1, 0, 0, 124'h0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 124'h33, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 124'h0,  0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 124'h0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 124'h0,  0, 0, 0, 0, 0, 0, 0));
    // single request 5A (also leaves the pointers off slot 0 before the wrap test)
    vecs.push_back(mk(1, 0, 0, 124'h0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 124'h5A, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 124'h0,  0, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 124'h0,  0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 124'h0,  0, 0, 0, 0, 0, 0, 0));

    // Reset
    reset = 1'b1;
    pcx_req_pq = 0; pcx_atom_pq = 0; request_mask_pa = 0; mb_fifo_full = 0;
    pcx_data_pa = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr",     {127'b0, mb_fifo_wr},   128'd0);
    chk("rst_grant",  {127'b0, pcx_grant_px}, 128'd0);
    chk("rst_req_pa", {127'b0, pcx_req_pa},   128'd0);
    chk("rst_req_px", {127'b0, pcx_req_px},   128'd0);
    chk("rst_atom",   {127'b0, pcx_atom_px},  128'd0);
    chk("rst_ovfl",   {127'b0, ovfl_err},     128'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Table-driven part
    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].req, vecs[i].atom, vecs[i].mask, 1'b0, vecs[i].data);
      if (vecs[i].push) sb_q.push_back(vecs[i].data);
      $display("vec %0d: req=%0b atom=%0b mask=%0b wr=%0b grant=%0b", i,
               vecs[i].req, vecs[i].atom, vecs[i].mask, mb_fifo_wr, pcx_grant_px);
      chk($sformatf("v%0d_wr", i),     {127'b0, mb_fifo_wr},   {127'b0, vecs[i].exp_wr});
      chk($sformatf("v%0d_grant", i),  {127'b0, pcx_grant_px}, {127'b0, vecs[i].exp_grant});
      chk($sformatf("v%0d_req_pa", i), {127'b0, pcx_req_pa},   {127'b0, vecs[i].exp_req_pa});
      chk($sformatf("v%0d_req_px", i), {127'b0, pcx_req_px},   {127'b0, vecs[i].exp_req_px});
      chk($sformatf("v%0d_atom_px", i),{127'b0, pcx_atom_px},  {127'b0, vecs[i].exp_atom_px});
      chk($sformatf("v%0d_ovfl", i),   {127'b0, ovfl_err},     {127'b0, vecs[i].exp_ovfl});
    end

    // Backpressure: fill three entries, release, drain in order; repeat so pointers wrap
    for (int r = 0; r < 5; r++) begin
      cyc(1, 0, 0, 1, '0);
      for (int k = 0; k < 3; k++) begin
        p = PKT_W'(32'hB000 + r * 16 + k);
        cyc((k < 2) ? 1'b1 : 1'b0, 0, 0, 1, p);
        sb_q.push_back(p);
      end
      cyc(0, 0, 0, 1, '0);
      chk($sformatf("bp%0d_hold_wr", r), {127'b0, mb_fifo_wr}, 128'd0);
      for (int k = 0; k < 5; k++) begin
        cyc(0, 0, 0, 0, '0);
        $display("bp round %0d drain %0d: wr=%0b grant=%0b", r, k, mb_fifo_wr, pcx_grant_px);
        chk($sformatf("bp%0d_d%0d_wr", r, k), {127'b0, mb_fifo_wr},
            {127'b0, (k < 3) ? 1'b1 : 1'b0});
        chk($sformatf("bp%0d_d%0d_grant", r, k), {127'b0, pcx_grant_px},
            {127'b0, (k >= 1 && k < 4) ? 1'b1 : 1'b0});
      end
    end

    // Overflow: a fourth request while three are held and the link is full
    cyc(1, 0, 0, 1, '0);
    for (int k = 0; k < 3; k++) begin
      p = PKT_W'(32'hC000 + k);
      cyc(1, 0, 0, 1, p);
      sb_q.push_back(p);
    end
    cyc(0, 0, 0, 1, PKT_W'(32'hCBAD));
    chk("ovfl_before", {127'b0, ovfl_err}, 128'd0);
    cyc(0, 0, 0, 1, '0);
    $display("overflow: ovfl_err=%0b", ovfl_err);
    chk("ovfl_set", {127'b0, ovfl_err}, 128'd1);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 0, '0);
      chk($sformatf("ovfl_d%0d_wr", k), {127'b0, mb_fifo_wr},
          {127'b0, (k < 3) ? 1'b1 : 1'b0});
    end
    chk("ovfl_sticky", {127'b0, ovfl_err}, 128'd1);
    chk("ovfl_drained", 128'(sb_q.size()), 128'd0);

    // Reset mid-operation with two entries held and a grant pending
    cyc(1, 0, 0, 1, '0);
    for (int k = 0; k < 3; k++) begin
      p = PKT_W'(32'hE000 + k);
      cyc((k < 2) ? 1'b1 : 1'b0, 0, 0, 1, p);
      sb_q.push_back(p);
    end
    cyc(0, 0, 0, 1, '0);
    cyc(0, 0, 0, 0, '0);
    chk("mid_pop_wr", {127'b0, mb_fifo_wr}, 128'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    mb_fifo_full = 1'b1;
    @(negedge clk);
    chk("mid_grant_pending", {127'b0, pcx_grant_px}, 128'd1);
    sb_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    mb_fifo_full = 1'b0;
    @(negedge clk);
    $display("after mid reset: wr=%0b grant=%0b ovfl=%0b", mb_fifo_wr, pcx_grant_px, ovfl_err);
    chk("mid_rst_wr",    {127'b0, mb_fifo_wr},   128'd0);
    chk("mid_rst_grant", {127'b0, pcx_grant_px}, 128'd0);
    chk("mid_rst_ovfl",  {127'b0, ovfl_err},     128'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, '0);
      chk($sformatf("mid_empty%0d_wr", k), {127'b0, mb_fifo_wr}, 128'd0);
    end

    // One more packet after reset to confirm clean restart
    cyc(1, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, 124'hF00D);
    sb_q.push_back(124'hF00D);
    cyc(0, 0, 0, 0, '0);
    chk("post_rst_wr", {127'b0, mb_fifo_wr}, 128'd1);
    cyc(0, 0, 0, 0, '0);
    chk("post_rst_grant", {127'b0, pcx_grant_px}, 128'd1);
    cyc(0, 0, 0, 0, '0);
    chk("final_sb_empty", 128'(sb_q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
